axi4_sram_slave: RTL and testbench
==================================

AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

Interface
REQ-001 SHALL have parameter N, default 4, bytes per data beat (power of two, 1..64).
REQ-002 SHALL have parameter I, default 4, ID width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, memory size in N-byte words.
REQ-004 SHALL have port ACLK, input, 1 bit, single clock; all logic samples on its rising edge.
REQ-005 SHALL have port ARESET, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have the AW channel as inputs: AWID [I], AWADDR [32], AWREGION [4], AWLEN [8], AWSIZE [3], AWBURST [2], AWLOCK [1], AWCACHE [4], AWPROT [3], AWQOS [4] and AWVALID [1], plus output AWREADY [1].
REQ-007 SHALL have the W channel as inputs: WDATA [8N], WSTRB [N], WLAST [1] and WVALID [1], plus output WREADY [1].
REQ-008 SHALL have the B channel as outputs BID [I], BRESP [2] and BVALID [1], plus input BREADY [1].
REQ-009 SHALL have the AR channel as inputs mirroring AW (ARID through ARQOS, ARVALID), plus output ARREADY [1].
REQ-010 SHALL have the R channel as outputs RID [I], RDATA [8N], RRESP [2], RLAST [1] and RVALID [1], plus input RREADY [1].

Function
REQ-011 SHALL run independent write and read FSMs, each with one outstanding burst.
REQ-012 SHALL implement the write FSM as W_IDLE -> W_DATA on an AW handshake, W_DATA -> W_RESP after beat AWLEN+1 is accepted, and W_RESP -> W_IDLE on a B handshake.
REQ-013 SHALL assert AWREADY only in W_IDLE, WREADY only in W_DATA, and BVALID only in W_RESP.
REQ-014 SHALL, on each W handshake, write the byte lanes enabled by WSTRB at the current word index, then advance the address.
REQ-015 SHALL report BRESP=OKAY (2'b00) unless a SLVERR condition occurred during the burst, in which case BRESP=2'b10; BID SHALL equal the captured AWID.
REQ-016 SHALL flag a WLAST mismatch (high before the final beat, or low on the final beat) as SLVERR. The burst SHALL still end on beat count AWLEN+1 only.
REQ-017 SHALL implement the read FSM as R_IDLE -> R_DATA on an AR handshake, and R_DATA -> R_IDLE on the R handshake of the beat with RLAST=1.
REQ-018 SHALL assert ARREADY only in R_IDLE.
REQ-019 SHALL assert RVALID in the cycle after the AR handshake, presenting registered data for the first address.
REQ-020 SHALL, on each non-final R handshake, load the next beat in the same edge so that RVALID stays high, sustaining one beat per cycle.
REQ-021 SHALL hold RID, RDATA, RRESP, RLAST and RVALID stable while RVALID=1 and RREADY=0.
REQ-022 SHALL drive RLAST=1 on beat ARLEN+1 only.
REQ-023 SHALL compute the word index as addr/N. An index >= DEPTH SHALL produce SLVERR for that beat: read returns RDATA=0, and write updates nothing.
REQ-024 SHALL compute the next address per burst type:
  - FIXED (00): address unchanged.
  - INCR (01): next = (addr aligned down to 2^SIZE) + 2^SIZE, modulo 2^32.
  - WRAP (10): same as INCR, but the address wraps to the boundary floor(start/((LEN+1)<<SIZE))*((LEN+1)<<SIZE) when it reaches the boundary plus (LEN+1)<<SIZE.
REQ-025 SHALL treat any of the following as SLVERR on every beat of the burst, with no memory write:
  - SIZE > log2(N);
  - BURST = 11;
  - WRAP with LEN not in {1,3,7,15}.
REQ-026 SHALL return the full N-byte word for narrow reads and apply WSTRB unmodified for narrow writes.
REQ-027 SHALL, when a write and a read hit the same word in the same cycle, return the pre-write contents to the read.
REQ-028 SHALL ignore REGION, LOCK, CACHE, PROT and QOS, and SHALL never return EXOKAY.

Reset
REQ-029 SHALL, while ARESET=1, hold both FSMs in IDLE and drive every output to 0, including AWREADY and ARREADY.
REQ-030 SHALL drive AWREADY=1 and ARREADY=1 on the first rising edge after ARESET deasserts.
REQ-031 SHALL, on reset assertion mid-burst, abort the burst immediately; beats already written SHALL remain in memory, and no B or R response SHALL be issued for the aborted burst.
REQ-032 SHALL NOT reset memory contents.

Verification
REQ-033 Single write then read: AW addr 0x10, LEN 0, SIZE 2, WDATA 0xDEADBEEF, WSTRB 0xF; then AR to the same address -> BRESP 00, and a single R beat RDATA 0xDEADBEEF, RLAST=1, RVALID one cycle after AR handshake.
REQ-034 INCR burst with backpressure: write 4 beats from 0x20 (0x1..0x4), then read LEN 3 with RREADY toggling 1,0,1,0 -> beats 0x1..0x4 in order, outputs stable during RREADY=0, RLAST only on beat 4.
REQ-035 WRAP burst: read LEN 3, SIZE 2, start 0x38 -> addresses 0x38, 0x3C, 0x30, 0x34 in that order.
REQ-036 Error paths:
  - write to 0x400 (index 256) -> BRESP 10, memory unchanged;
  - AWBURST 11 -> BRESP 10;
  - WLAST high on beat 1 of LEN 2 -> 3 beats accepted, BRESP 10.
REQ-037 Strobes and collision: WSTRB 0x5 over 0xFFFFFFFF with WDATA 0x11223344 -> read 0xFF22FF44; same-cycle read and write to one word -> read returns old value.
REQ-038 Reset mid-burst: ARESET pulsed after beat 2 of an 8-beat write -> BVALID never asserted, beats 1-2 stored, and AWREADY=1 one edge after ARESET falls.

Source files
------------

// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between a master and the SRAM slave; N bytes per beat, I-bit IDs.
interface axi4_sram_slave_if #(
    parameter int N = 4,
    parameter int I = 4
);
    logic [I-1:0]   AWID;
    logic [31:0]    AWADDR;
    logic [3:0]     AWREGION;
    logic [7:0]     AWLEN;
    logic [2:0]     AWSIZE;
    logic [1:0]     AWBURST;
    logic           AWLOCK;
    logic [3:0]     AWCACHE;
    logic [2:0]     AWPROT;
    logic [3:0]     AWQOS;
    logic           AWVALID;
    logic           AWREADY;

    logic [8*N-1:0] WDATA;
    logic [N-1:0]   WSTRB;
    logic           WLAST;
    logic           WVALID;
    logic           WREADY;

    logic [I-1:0]   BID;
    logic [1:0]     BRESP;
    logic           BVALID;
    logic           BREADY;

    logic [I-1:0]   ARID;
    logic [31:0]    ARADDR;
    logic [3:0]     ARREGION;
    logic [7:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic [1:0]     ARBURST;
    logic           ARLOCK;
    logic [3:0]     ARCACHE;
    logic [2:0]     ARPROT;
    logic [3:0]     ARQOS;
    logic           ARVALID;
    logic           ARREADY;

    logic [I-1:0]   RID;
    logic [8*N-1:0] RDATA;
    logic [1:0]     RRESP;
    logic           RLAST;
    logic           RVALID;
    logic           RREADY;

    modport slave (
        input  AWID, AWADDR, AWREGION, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARREGION, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWREGION, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARREGION, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave over a DEPTH x N-byte SRAM; independent single-outstanding write and read bursts.
module axi4_sram_slave #(
    parameter int N     = 4,
    parameter int I     = 4,
    parameter int DEPTH = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    axi4_sram_slave_if.slave    s_axi
);
    localparam int unsigned LGN = $clog2(N);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW  = 8 * N;
    localparam logic [2:0]  MAXSZ = 3'(LGN);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    function automatic logic [31:0] f_next_addr(input logic [31:0] a, input logic [2:0] sz,
                                                input logic [1:0] bu, input logic [7:0] ln);
        logic [31:0] step;
        logic [31:0] incr;
        logic [31:0] span;
        logic [31:0] lower;
        step  = 32'd1 << sz;
        incr  = (a & ~(step - 32'd1)) + step;
        span  = ({24'd0, ln} + 32'd1) << sz;
        lower = a & ~(span - 32'd1);
        case (bu)
            2'b00:   return a;
            2'b10:   return (incr == lower + span) ? lower : incr;
            default: return incr;
        endcase
    endfunction

    function automatic logic f_bad(input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] ln);
        return (sz > MAXSZ) || (bu == 2'b11) ||
               ((bu == 2'b10) && !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15));
    endfunction

    function automatic logic f_in_range(input logic [31:0] a);
        return (a >> LGN) < 32'(DEPTH);
    endfunction

    function automatic logic [AW-1:0] f_idx(input logic [31:0] a);
        return AW'(a >> LGN);
    endfunction

    logic [DW-1:0] r_mem [DEPTH];

    w_state_t      r_wstate, w_wstate_nxt;
    r_state_t      r_rstate, w_rstate_nxt;
    logic          r_live;

    logic [31:0]   r_waddr;
    logic [7:0]    r_wlen, r_wcnt;
    logic [2:0]    r_wsize;
    logic [1:0]    r_wburst;
    logic [I-1:0]  r_wid;
    logic          r_wbad, r_werr;

    logic [31:0]   r_raddr;
    logic [7:0]    r_rlen, r_rcnt;
    logic [2:0]    r_rsize;
    logic [1:0]    r_rburst;
    logic [I-1:0]  r_rid;
    logic          r_rbad, r_rlast;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_rresp;

    logic          w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic          w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic          w_wlast_beat, w_win, w_ar_err, w_rn_err;
    logic [31:0]   w_rnext;
    logic          w_unused;

    assign w_unused = ^{s_axi.AWREGION, s_axi.AWLOCK, s_axi.AWCACHE, s_axi.AWPROT, s_axi.AWQOS,
                        s_axi.ARREGION, s_axi.ARLOCK, s_axi.ARCACHE, s_axi.ARPROT, s_axi.ARQOS};

    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_win        = f_in_range(r_waddr);
    assign w_aw_hs      = s_axi.AWVALID && w_awready;
    assign w_w_hs       = s_axi.WVALID && w_wready;
    assign w_ar_hs      = s_axi.ARVALID && w_arready;
    assign w_r_hs       = w_rvalid && s_axi.RREADY;
    assign w_ar_err     = f_bad(s_axi.ARSIZE, s_axi.ARBURST, s_axi.ARLEN) || !f_in_range(s_axi.ARADDR);
    assign w_rnext      = f_next_addr(r_raddr, r_rsize, r_rburst, r_rlen);
    assign w_rn_err     = r_rbad || !f_in_range(w_rnext);

    // r_live keeps both READYs low until the first edge after reset release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_live   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_live   <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = r_live;
                if (s_axi.AWVALID && r_live) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (s_axi.WVALID && w_wlast_beat) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = r_live;
                if (s_axi.ARVALID && r_live) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (s_axi.RREADY && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wid    <= '0;
            r_wbad   <= 1'b0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_waddr  <= s_axi.AWADDR;
            r_wlen   <= s_axi.AWLEN;
            r_wcnt   <= '0;
            r_wsize  <= s_axi.AWSIZE;
            r_wburst <= s_axi.AWBURST;
            r_wid    <= s_axi.AWID;
            r_wbad   <= f_bad(s_axi.AWSIZE, s_axi.AWBURST, s_axi.AWLEN);
            r_werr   <= f_bad(s_axi.AWSIZE, s_axi.AWBURST, s_axi.AWLEN);
        end else if (w_w_hs) begin
            r_waddr  <= f_next_addr(r_waddr, r_wsize, r_wburst, r_wlen);
            r_wcnt   <= r_wcnt + 8'd1;
            r_werr   <= r_werr || !w_win || (s_axi.WLAST != w_wlast_beat);
        end
    end

    // Memory is never reset; WREADY is forced low asynchronously by reset, so no write can land then.
    always_ff @(posedge ACLK) begin
        if (w_w_hs && !r_wbad && w_win) begin
            for (int unsigned b = 0; b < N; b++) begin
                if (s_axi.WSTRB[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rid    <= '0;
            r_rbad   <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else if (w_ar_hs) begin
            r_raddr  <= s_axi.ARADDR;
            r_rlen   <= s_axi.ARLEN;
            r_rcnt   <= '0;
            r_rsize  <= s_axi.ARSIZE;
            r_rburst <= s_axi.ARBURST;
            r_rid    <= s_axi.ARID;
            r_rbad   <= f_bad(s_axi.ARSIZE, s_axi.ARBURST, s_axi.ARLEN);
            r_rlast  <= (s_axi.ARLEN == 8'd0);
            r_rdata  <= w_ar_err ? '0 : r_mem[f_idx(s_axi.ARADDR)];
            r_rresp  <= w_ar_err ? 2'b10 : 2'b00;
        end else if (w_r_hs && !r_rlast) begin
            r_raddr  <= w_rnext;
            r_rcnt   <= r_rcnt + 8'd1;
            r_rlast  <= ((r_rcnt + 8'd1) == r_rlen);
            r_rdata  <= w_rn_err ? '0 : r_mem[f_idx(w_rnext)];
            r_rresp  <= w_rn_err ? 2'b10 : 2'b00;
        end else if (w_r_hs) begin
            r_rlast  <= 1'b0;
        end
    end

    assign s_axi.AWREADY = w_awready;
    assign s_axi.WREADY  = w_wready;
    assign s_axi.BVALID  = w_bvalid;
    assign s_axi.BID     = r_wid;
    assign s_axi.BRESP   = {r_werr, 1'b0};
    assign s_axi.ARREADY = w_arready;
    assign s_axi.RVALID  = w_rvalid;
    assign s_axi.RID     = r_rid;
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;
    assign s_axi.RLAST   = r_rlast;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: single-beat vector table plus burst, wrap, collision and reset sequences.
module tb_axi4_sram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    axi4_sram_slave_if #(.N(4), .I(4)) bus ();

    axi4_sram_slave #(.N(4), .I(4), .DEPTH(256)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .s_axi  (bus.slave)
    );

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  wsize;
        logic [1:0]  wburst;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int unsigned n = 0;
        bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst; bus.AWID = id;
        bus.AWVALID = 1'b1;
        while (!bus.AWREADY && n < 50) begin tick(); n++; end
        if (!bus.AWREADY) chk("aw_ready_timeout", 32'(bus.AWREADY), 32'd1);
        tick();
        bus.AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int unsigned n = 0;
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last;
        bus.WVALID = 1'b1;
        while (!bus.WREADY && n < 50) begin tick(); n++; end
        if (!bus.WREADY) chk("w_ready_timeout", 32'(bus.WREADY), 32'd1);
        tick();
        bus.WVALID = 1'b0;
    endtask

    task automatic b_expect(input string nm, input logic [1:0] resp, input logic [3:0] id);
        int unsigned n = 0;
        while (!bus.BVALID && n < 50) begin tick(); n++; end
        chk({nm, "_bvalid"}, 32'(bus.BVALID), 32'd1);
        chk({nm, "_bresp"}, 32'(bus.BRESP), 32'(resp));
        chk({nm, "_bid"}, 32'(bus.BID), 32'(id));
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        chk({nm, "_bvalid_drop"}, 32'(bus.BVALID), 32'd0);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int unsigned n = 0;
        bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst; bus.ARID = id;
        bus.ARVALID = 1'b1;
        while (!bus.ARREADY && n < 50) begin tick(); n++; end
        if (!bus.ARREADY) chk("ar_ready_timeout", 32'(bus.ARREADY), 32'd1);
        tick();
        bus.ARVALID = 1'b0;
    endtask

    task automatic r_expect(input string nm, input logic [31:0] data, input logic [1:0] resp,
                            input logic last, input logic [3:0] id);
        chk({nm, "_rvalid"}, 32'(bus.RVALID), 32'd1);
        chk({nm, "_rdata"}, bus.RDATA, data);
        chk({nm, "_rresp"}, 32'(bus.RRESP), 32'(resp));
        chk({nm, "_rlast"}, 32'(bus.RLAST), 32'(last));
        chk({nm, "_rid"}, 32'(bus.RID), 32'(id));
    endtask

    task automatic wr_single(input logic [31:0] addr, input logic [31:0] data);
        aw_send(addr, 8'd0, 3'd2, 2'b01, 4'd0);
        w_send(data, 4'hF, 1'b1);
        b_expect("prewrite", 2'b00, 4'd0);
    endtask

    task automatic rd_single(input string nm, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp);
        ar_send(addr, 8'd0, 3'd2, 2'b01, 4'd9);
        r_expect(nm, data, resp, 1'b1, 4'd9);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        chk({nm, "_rvalid_drop"}, 32'(bus.RVALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_data;
        logic [31:0] wrap_exp [4];
        int          seen_b;

        vecs[0]  = '{32'h10,  32'hDEADBEEF, 4'hF, 3'd2, 2'b01, 2'b00, 32'h10,  32'hDEADBEEF, 2'b00};
        vecs[1]  = '{32'h00,  32'hA5A5A5A5, 4'hF, 3'd2, 2'b01, 2'b00, 32'h00,  32'hA5A5A5A5, 2'b00};
        vecs[2]  = '{32'h400, 32'h12345678, 4'hF, 3'd2, 2'b01, 2'b10, 32'h00,  32'hA5A5A5A5, 2'b00};
        vecs[3]  = '{32'h44,  32'hFFFFFFFF, 4'hF, 3'd2, 2'b01, 2'b00, 32'h44,  32'hFFFFFFFF, 2'b00};
        vecs[4]  = '{32'h44,  32'h11223344, 4'h5, 3'd2, 2'b01, 2'b00, 32'h44,  32'hFF22FF44, 2'b00};
        vecs[5]  = '{32'h48,  32'h0BADF00D, 4'hF, 3'd2, 2'b01, 2'b00, 32'h48,  32'h0BADF00D, 2'b00};
        vecs[6]  = '{32'h48,  32'hCAFEF00D, 4'hF, 3'd2, 2'b11, 2'b10, 32'h48,  32'h0BADF00D, 2'b00};
        vecs[7]  = '{32'h48,  32'hCAFEF00D, 4'hF, 3'd3, 2'b01, 2'b10, 32'h48,  32'h0BADF00D, 2'b00};
        vecs[8]  = '{32'h50,  32'h00000001, 4'hF, 3'd2, 2'b01, 2'b00, 32'h400, 32'h00000000, 2'b10};
        vecs[9]  = '{32'h51,  32'h0000AB00, 4'h2, 3'd0, 2'b01, 2'b00, 32'h50,  32'h0000AB01, 2'b00};
        vecs[10] = '{32'h48,  32'hCAFEF00D, 4'hF, 3'd2, 2'b10, 2'b10, 32'h48,  32'h0BADF00D, 2'b00};

        bus.AWID = '0; bus.AWADDR = '0; bus.AWREGION = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
        bus.AWBURST = '0; bus.AWLOCK = 1'b0; bus.AWCACHE = '0; bus.AWPROT = '0; bus.AWQOS = '0;
        bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARREGION = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
        bus.ARBURST = '0; bus.ARLOCK = 1'b0; bus.ARCACHE = '0; bus.ARPROT = '0; bus.ARQOS = '0;
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        // Reset state and release timing
        tick(); tick();
        chk("rst_awready", 32'(bus.AWREADY), 32'd0);
        chk("rst_arready", 32'(bus.ARREADY), 32'd0);
        chk("rst_wready", 32'(bus.WREADY), 32'd0);
        chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
        chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
        chk("rst_rlast", 32'(bus.RLAST), 32'd0);
        chk("rst_rdata", bus.RDATA, 32'd0);
        rst = 1'b0;
        chk("rel_awready_pre", 32'(bus.AWREADY), 32'd0);
        tick();
        chk("rel_awready", 32'(bus.AWREADY), 32'd1);
        chk("rel_arready", 32'(bus.ARREADY), 32'd1);

        // Single-beat table
        for (int i = 0; i < 11; i++) begin
            aw_send(vecs[i].waddr, 8'd0, vecs[i].wsize, vecs[i].wburst, 4'(i));
            w_send(vecs[i].wdata, vecs[i].wstrb, 1'b1);
            b_expect($sformatf("vec%0d", i), vecs[i].exp_bresp, 4'(i));
            rd_single($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rdata, vecs[i].exp_rresp);
        end

        // INCR burst with RREADY backpressure
        aw_send(32'h20, 8'd3, 3'd2, 2'b01, 4'd3);
        for (int k = 1; k <= 4; k++) w_send(32'(k), 4'hF, k == 4);
        b_expect("incr", 2'b00, 4'd3);
        ar_send(32'h20, 8'd3, 3'd2, 2'b01, 4'd5);
        for (int k = 1; k <= 4; k++) begin
            bus.RREADY = 1'b0;
            r_expect($sformatf("incr_b%0d", k), 32'(k), 2'b00, k == 4, 4'd5);
            hold_data = bus.RDATA;
            tick();
            chk($sformatf("incr_b%0d_hold", k), bus.RDATA, hold_data);
            r_expect($sformatf("incr_b%0d_held", k), 32'(k), 2'b00, k == 4, 4'd5);
            bus.RREADY = 1'b1;
            tick();
        end
        bus.RREADY = 1'b0;
        chk("incr_rvalid_end", 32'(bus.RVALID), 32'd0);

        // WRAP read from 0x38 over words holding their own address
        aw_send(32'h30, 8'd3, 3'd2, 2'b01, 4'd1);
        for (int k = 0; k < 4; k++) w_send(32'h30 + 32'(4 * k), 4'hF, k == 3);
        b_expect("wrapfill", 2'b00, 4'd1);
        wrap_exp[0] = 32'h38; wrap_exp[1] = 32'h3C; wrap_exp[2] = 32'h30; wrap_exp[3] = 32'h34;
        ar_send(32'h38, 8'd3, 3'd2, 2'b10, 4'd6);
        bus.RREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r_expect($sformatf("wrap_b%0d", k), wrap_exp[k], 2'b00, k == 3, 4'd6);
            tick();
        end
        bus.RREADY = 1'b0;
        chk("wrap_rvalid_end", 32'(bus.RVALID), 32'd0);

        // WLAST early on a 3-beat burst, and WLAST missing on a 1-beat burst
        aw_send(32'h60, 8'd2, 3'd2, 2'b01, 4'd7);
        w_send(32'd7, 4'hF, 1'b1);
        w_send(32'd8, 4'hF, 1'b0);
        chk("wlast_still_wready", 32'(bus.WREADY), 32'd1);
        w_send(32'd9, 4'hF, 1'b1);
        b_expect("wlast_early", 2'b10, 4'd7);
        aw_send(32'h64, 8'd0, 3'd2, 2'b01, 4'd8);
        w_send(32'd1, 4'hF, 1'b0);
        b_expect("wlast_missing", 2'b10, 4'd8);

        // Same-cycle write and read of one word
        wr_single(32'h70, 32'h11111111);
        aw_send(32'h70, 8'd0, 3'd2, 2'b01, 4'd2);
        chk("coll_wready", 32'(bus.WREADY), 32'd1);
        chk("coll_arready", 32'(bus.ARREADY), 32'd1);
        bus.WDATA = 32'h22222222; bus.WSTRB = 4'hF; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h70; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01; bus.ARID = 4'd4;
        bus.ARVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        bus.ARVALID = 1'b0;
        r_expect("coll", 32'h11111111, 2'b00, 1'b1, 4'd4);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        b_expect("coll", 2'b00, 4'd2);
        rd_single("coll_after", 32'h70, 32'h22222222, 2'b00);

        // Reset in the middle of an 8-beat write
        aw_send(32'h80, 8'd7, 3'd2, 2'b01, 4'd1);
        w_send(32'hA1, 4'hF, 1'b0);
        w_send(32'hA2, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wready", 32'(bus.WREADY), 32'd0);
        chk("mid_rst_awready", 32'(bus.AWREADY), 32'd0);
        chk("mid_rst_bvalid", 32'(bus.BVALID), 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk("mid_rel_awready_pre", 32'(bus.AWREADY), 32'd0);
        tick();
        chk("mid_rel_awready", 32'(bus.AWREADY), 32'd1);
        chk("mid_rel_wready", 32'(bus.WREADY), 32'd0);
        seen_b = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.BVALID) seen_b = 1;
            tick();
        end
        chk("mid_no_bvalid", 32'(seen_b), 32'd0);
        ar_send(32'h80, 8'd1, 3'd2, 2'b01, 4'd3);
        bus.RREADY = 1'b1;
        r_expect("mid_b1", 32'hA1, 2'b00, 1'b0, 4'd3);
        tick();
        r_expect("mid_b2", 32'hA2, 2'b00, 1'b1, 4'd3);
        tick();
        bus.RREADY = 1'b0;
        chk("mid_rvalid_end", 32'(bus.RVALID), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
